// File: rtl/writeback_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_retire_unit
//  Description : Registers execute-stage result bundles into a writeback slot,
//                buffers returning load data in a small queue, and merges both
//                onto the two register-file write ports. Drives the writeback_*
//                and memory_* bypass sources for the forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_retire_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // execute bundle
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [DATA_W-1:0]        ex_result_a_i,
  input  logic [DATA_W-1:0]        ex_result_b_i,
  input  logic [ADDR_W-1:0]        ex_rd1_i,
  input  logic [ADDR_W-1:0]        ex_rd2_i,
  input  logic                     ex_wr_en1_i,
  input  logic                     ex_wr_en2_i,
  input  logic                     ex_mem_read_i,
  // load return
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [ADDR_W-1:0]        ld_rd_i,
  input  logic [DATA_W-1:0]        ld_data_i,
  // writeback bypass source
  output logic                     writeback_valid_o,
  output logic [DATA_W-1:0]        writeback_result_a_o,
  output logic [DATA_W-1:0]        writeback_result_b_o,
  output logic [ADDR_W-1:0]        writeback_rd1_o,
  output logic [ADDR_W-1:0]        writeback_rd2_o,
  output logic                     writeback_wr_en1_o,
  output logic                     writeback_wr_en2_o,
  // memory bypass source
  output logic                     memory_valid_o,
  output logic                     memory_wr_en_o,
  output logic [ADDR_W-1:0]        memory_rd_o,
  output logic [DATA_W-1:0]        memory_result_o,
  // register-file write ports
  output logic                     rf_we1_o,
  output logic                     rf_we2_o,
  output logic [ADDR_W-1:0]        rf_waddr1_o,
  output logic [ADDR_W-1:0]        rf_waddr2_o,
  output logic [DATA_W-1:0]        rf_wdata1_o,
  output logic [DATA_W-1:0]        rf_wdata2_o,
  // hazard and performance
  output logic [(1<<ADDR_W)-1:0]   ld_pending_mask_o,
  output logic [31:0]              lq_full_stalls_o,
  output logic [31:0]              loads_retired_o
);

  localparam int              PTR_W   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int              NREG    = 1 << ADDR_W;
  localparam logic [PTR_W:0]  LQ_FULL = (PTR_W+1)'(LQ_DEPTH);

  // writeback slot
  logic                slot_valid_q, slot_valid_d;
  logic [DATA_W-1:0]   slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic [ADDR_W-1:0]   slot_rd1_q, slot_rd1_d, slot_rd2_q, slot_rd2_d;
  logic                slot_en1_q, slot_en1_d, slot_en2_q, slot_en2_d;

  // load queue
  logic [ADDR_W-1:0]   lq_rd_q   [LQ_DEPTH];
  logic [DATA_W-1:0]   lq_data_q [LQ_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;

  // counters
  logic [31:0]         stalls_q, stalls_d, retired_q, retired_d;

  // control
  logic                slot_stall, slot_retire, slot_we1, slot_we2;
  logic                port1_free, port2_free, lq_pop, lq_push, ex_accept;
  logic                ld_on_p1, ld_on_p2;
  logic [ADDR_W-1:0]   head_rd;
  logic [DATA_W-1:0]   head_data;
  logic [PTR_W-1:0]    entry_offs;

  assign head_rd   = lq_rd_q[head_q];
  assign head_data = lq_data_q[head_q];

  // Port arbitration between the slot and the load-queue head
  always_comb begin
    // A full queue behind a dual-write slot would deadlock; the head steals port 2.
    slot_stall  = slot_valid_q && slot_en1_q && slot_en2_q && (count_q == LQ_FULL);
    slot_retire = slot_valid_q && !slot_stall;
    // Same-destination dual write: port 2 (result B) is the architectural winner.
    slot_we1    = slot_retire && slot_en1_q && !(slot_en2_q && (slot_rd1_q == slot_rd2_q));
    slot_we2    = slot_retire && slot_en2_q;
    port2_free  = !slot_valid_q || slot_stall || !slot_en2_q;
    port1_free  = slot_retire && slot_en2_q && !slot_en1_q;
    lq_pop      = (count_q != '0) && (port2_free || port1_free);
    ld_on_p2    = lq_pop && port2_free;
    ld_on_p1    = lq_pop && !port2_free;
    ex_ready_o  = !slot_valid_q || slot_retire;
    ld_ready_o  = (count_q < LQ_FULL);
    ex_accept   = ex_valid_i && ex_ready_o;
    lq_push     = ld_valid_i && ld_ready_o && (ld_rd_i != '0);
  end

  // Register-file port and memory bypass muxing
  always_comb begin
    rf_we1_o        = slot_we1 || ld_on_p1;
    rf_we2_o        = slot_we2 || ld_on_p2;
    rf_waddr1_o     = ld_on_p1 ? head_rd   : (slot_we1 ? slot_rd1_q : '0);
    rf_wdata1_o     = ld_on_p1 ? head_data : (slot_we1 ? slot_a_q   : '0);
    rf_waddr2_o     = ld_on_p2 ? head_rd   : (slot_we2 ? slot_rd2_q : '0);
    rf_wdata2_o     = ld_on_p2 ? head_data : (slot_we2 ? slot_b_q   : '0);
    memory_valid_o  = lq_pop;
    memory_wr_en_o  = lq_pop;
    memory_rd_o     = lq_pop ? head_rd   : '0;
    memory_result_o = lq_pop ? head_data : '0;
  end

  // Pending-load destination mask from the live queue window
  always_comb begin
    ld_pending_mask_o = '0;
    entry_offs        = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      entry_offs = PTR_W'(i) - head_q;
      if ({1'b0, entry_offs} < count_q) begin
        ld_pending_mask_o[lq_rd_q[i]] = 1'b1;
      end
    end
    ld_pending_mask_o[0] = 1'b0;
  end

  // Next-state for slot, queue pointers and counters
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    slot_rd1_d   = slot_rd1_q;
    slot_rd2_d   = slot_rd2_q;
    slot_en1_d   = slot_en1_q;
    slot_en2_d   = slot_en2_q;
    if (ex_accept) begin
      slot_valid_d = 1'b1;
      slot_a_d     = ex_result_a_i;
      slot_b_d     = ex_result_b_i;
      slot_rd1_d   = ex_rd1_i;
      slot_rd2_d   = ex_rd2_i;
      // Slot A of a load bundle carries no result; its data returns via ld_*.
      slot_en1_d   = ex_wr_en1_i && !ex_mem_read_i && (ex_rd1_i != '0);
      slot_en2_d   = ex_wr_en2_i && (ex_rd2_i != '0);
    end else if (slot_retire) begin
      slot_valid_d = 1'b0;
      slot_en1_d   = 1'b0;
      slot_en2_d   = 1'b0;
    end
    head_d    = lq_pop  ? head_q + 1'b1 : head_q;
    tail_d    = lq_push ? tail_q + 1'b1 : tail_q;
    count_d   = count_q + (PTR_W+1)'(lq_push) - (PTR_W+1)'(lq_pop);
    stalls_d  = stalls_q  + 32'(slot_stall);
    retired_d = retired_q + 32'(lq_pop);
  end

  // Control-state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      slot_rd1_q   <= '0;
      slot_rd2_q   <= '0;
      slot_en1_q   <= 1'b0;
      slot_en2_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      stalls_q     <= '0;
      retired_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      slot_rd1_q   <= slot_rd1_d;
      slot_rd2_q   <= slot_rd2_d;
      slot_en1_q   <= slot_en1_d;
      slot_en2_q   <= slot_en2_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      stalls_q     <= stalls_d;
      retired_q    <= retired_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (!rst && lq_push) begin
      lq_rd_q[tail_q]   <= ld_rd_i;
      lq_data_q[tail_q] <= ld_data_i;
    end
  end

  assign writeback_valid_o    = slot_valid_q;
  assign writeback_result_a_o = slot_a_q;
  assign writeback_result_b_o = slot_b_q;
  assign writeback_rd1_o      = slot_rd1_q;
  assign writeback_rd2_o      = slot_rd2_q;
  assign writeback_wr_en1_o   = slot_en1_q;
  assign writeback_wr_en2_o   = slot_en2_q;
  assign lq_full_stalls_o     = stalls_q;
  assign loads_retired_o      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_retire_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_retire_unit
//  Description : Self-checking bench for writeback_retire_unit against a
//                transaction-level model (queue of loads, slot record).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_retire_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LQ     = 4;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid, ex_ready, ex_wr_en1, ex_wr_en2, ex_mem_read;
  logic [DATA_W-1:0] ex_a, ex_b, ld_data;
  logic [ADDR_W-1:0] ex_rd1, ex_rd2, ld_rd;
  logic ld_valid, ld_ready;
  logic wb_valid, wb_en1, wb_en2;
  logic [DATA_W-1:0] wb_a, wb_b;
  logic [ADDR_W-1:0] wb_rd1, wb_rd2;
  logic mem_valid, mem_wr_en;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic rf_we1, rf_we2;
  logic [ADDR_W-1:0] rf_waddr1, rf_waddr2;
  logic [DATA_W-1:0] rf_wdata1, rf_wdata2;
  logic [31:0] pend_mask;
  logic [31:0] stalls, retired;

  always #5 clk = ~clk;

  writeback_retire_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_result_a_i(ex_a), .ex_result_b_i(ex_b),
    .ex_rd1_i(ex_rd1), .ex_rd2_i(ex_rd2),
    .ex_wr_en1_i(ex_wr_en1), .ex_wr_en2_i(ex_wr_en2), .ex_mem_read_i(ex_mem_read),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_rd_i(ld_rd), .ld_data_i(ld_data),
    .writeback_valid_o(wb_valid), .writeback_result_a_o(wb_a), .writeback_result_b_o(wb_b),
    .writeback_rd1_o(wb_rd1), .writeback_rd2_o(wb_rd2),
    .writeback_wr_en1_o(wb_en1), .writeback_wr_en2_o(wb_en2),
    .memory_valid_o(mem_valid), .memory_wr_en_o(mem_wr_en),
    .memory_rd_o(mem_rd), .memory_result_o(mem_result),
    .rf_we1_o(rf_we1), .rf_we2_o(rf_we2),
    .rf_waddr1_o(rf_waddr1), .rf_waddr2_o(rf_waddr2),
    .rf_wdata1_o(rf_wdata1), .rf_wdata2_o(rf_wdata2),
    .ld_pending_mask_o(pend_mask),
    .lq_full_stalls_o(stalls), .loads_retired_o(retired)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; } load_t;
  load_t m_lq[$];
  bit                m_sv, m_en1, m_en2;
  logic [DATA_W-1:0] m_a, m_b;
  logic [ADDR_W-1:0] m_rd1, m_rd2;
  logic [31:0]       m_stalls, m_retired;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lq.delete();
    m_sv = 0; m_en1 = 0; m_en2 = 0;
    m_a = '0; m_b = '0; m_rd1 = '0; m_rd2 = '0;
    m_stalls = 0; m_retired = 0;
  endfunction

  // One clock: inputs already driven at the falling edge; check, then advance.
  task automatic cycle();
    bit stall, retire, e_we1, e_we2;
    int ld_port;
    int qsize;
    logic [31:0] e_mask;
    load_t head;
    #1;
    qsize  = m_lq.size();
    stall  = m_sv && m_en1 && m_en2 && (qsize == LQ);
    retire = m_sv && !stall;
    e_we1  = retire && m_en1 && !(m_en2 && m_rd1 == m_rd2);
    e_we2  = retire && m_en2;
    ld_port = 0;
    if (qsize > 0) begin
      head = m_lq[0];
      if (!m_sv || stall || !m_en2) ld_port = 2;
      else if (!m_en1)              ld_port = 1;
    end
    e_mask = '0;
    foreach (m_lq[i]) e_mask[m_lq[i].rd] = 1'b1;

    check_eq("ex_ready", ex_ready, !stall);
    check_eq("ld_ready", ld_ready, qsize < LQ);
    check_eq("wb_valid", wb_valid, m_sv);
    check_eq("wb_en1", wb_en1, m_en1);
    check_eq("wb_en2", wb_en2, m_en2);
    if (m_sv) begin
      check_eq("wb_rd1", wb_rd1, m_rd1);
      check_eq("wb_rd2", wb_rd2, m_rd2);
      check_eq("wb_a", wb_a, m_a);
      check_eq("wb_b", wb_b, m_b);
    end
    check_eq("rf_we1", rf_we1, e_we1 || ld_port == 1);
    check_eq("rf_we2", rf_we2, e_we2 || ld_port == 2);
    if (ld_port == 1) begin
      check_eq("rf_waddr1_ld", rf_waddr1, head.rd);
      check_eq("rf_wdata1_ld", rf_wdata1, head.data);
    end else if (e_we1) begin
      check_eq("rf_waddr1", rf_waddr1, m_rd1);
      check_eq("rf_wdata1", rf_wdata1, m_a);
    end
    if (ld_port == 2) begin
      check_eq("rf_waddr2_ld", rf_waddr2, head.rd);
      check_eq("rf_wdata2_ld", rf_wdata2, head.data);
    end else if (e_we2) begin
      check_eq("rf_waddr2", rf_waddr2, m_rd2);
      check_eq("rf_wdata2", rf_wdata2, m_b);
    end
    check_eq("mem_valid", mem_valid, ld_port != 0);
    check_eq("mem_wr_en", mem_wr_en, ld_port != 0);
    if (ld_port != 0) begin
      check_eq("mem_rd", mem_rd, head.rd);
      check_eq("mem_result", mem_result, head.data);
    end
    check_eq("pend_mask", pend_mask, e_mask);
    check_eq("lq_full_stalls", stalls, m_stalls);
    check_eq("loads_retired", retired, m_retired);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ld_port != 0) begin
        void'(m_lq.pop_front());
        m_retired++;
      end
      if (stall) m_stalls++;
      if (ex_valid && !stall) begin
        m_sv  = 1;
        m_a   = ex_a;   m_b   = ex_b;
        m_rd1 = ex_rd1; m_rd2 = ex_rd2;
        m_en1 = ex_wr_en1 && !ex_mem_read && ex_rd1 != 0;
        m_en2 = ex_wr_en2 && ex_rd2 != 0;
      end else if (retire) begin
        m_sv = 0; m_en1 = 0; m_en2 = 0;
      end
      if (ld_valid && qsize < LQ && ld_rd != 0) m_lq.push_back('{rd: ld_rd, data: ld_data});
    end
    @(negedge clk);
  endtask

  task automatic drive_ex(input bit v, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] a,
                          input logic [ADDR_W-1:0] r2, input logic [DATA_W-1:0] b,
                          input bit e1, input bit e2, input bit mr);
    ex_valid = v; ex_rd1 = r1; ex_a = a; ex_rd2 = r2; ex_b = b;
    ex_wr_en1 = e1; ex_wr_en2 = e2; ex_mem_read = mr;
  endtask

  task automatic drive_ld(input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    ld_valid = v; ld_rd = r; ld_data = d;
  endtask

  task automatic idle();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0);
    drive_ld(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    cycle();                    // reset state held
    rst = 1'b0;
    cycle();

    // ALU bundle r3/r4
    drive_ex(1, 3, 32'h11, 4, 32'h22, 1, 1, 0);
    cycle();
    idle();
    cycle();
    cycle();

    // single load return to r7 with empty slot
    drive_ld(1, 7, 32'h55);
    cycle();
    idle();
    cycle();
    cycle();

    // same destination on both slots, then r0 on slot A
    drive_ex(1, 5, 32'h1, 5, 32'h2, 1, 1, 0);
    cycle();
    drive_ex(1, 0, 32'h9, 6, 32'h66, 1, 1, 0);
    cycle();
    // load bundle: slot A result arrives later via the load-return path
    drive_ex(1, 9, 32'hdead, 10, 32'haa, 1, 1, 1);
    cycle();
    idle();
    drive_ld(1, 0, 32'h77);     // r0 load is accepted but dropped
    cycle();
    idle();
    cycle();

    // dual-write stream while loads arrive until the queue fills and stalls
    for (int i = 0; i < 8; i++) begin
      drive_ex(1, 5'(1 + i), 32'(i), 5'(16 + i), 32'(100 + i), 1, 1, 0);
      drive_ld(1, 5'(20 + i), 32'(32'h500 + i));
      cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) cycle();

    // reset with slot full and three queued loads
    drive_ex(1, 1, 1, 2, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_ld(1, 5'(11 + i), 32'(i));
      cycle();
    end
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      drive_ex($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
               $urandom_range(0, 5) == 0);
      drive_ld($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
